eeprom_access_sequencer: RTL

- Sits between two independent requesters and one at25010_interface instance; owns that interface's command port.
- Turns single-byte read/write requests into complete AT25010 command sequences:
  - write: WREN, then WRITE, then RDSR polling until WIP (status bit0) clears;
  - read: READ.
- Arbitrates the two requesters round-robin and returns one response per accepted request.

---
 rtl/eeprom_pkg.sv | 29 ++
 rtl/rr_arbiter_2.sv | 34 +++
 rtl/eeprom_access_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/eeprom_pkg.sv
// Shared encodings for the AT25010 access sequencer: command types,
// status register bit positions and the sequencer state enum.
package eeprom_pkg;

    localparam logic [2:0] CMD_WREN  = 3'd0;
    localparam logic [2:0] CMD_WRDI  = 3'd1;
    localparam logic [2:0] CMD_RDSR  = 3'd2;
    localparam logic [2:0] CMD_WRSR  = 3'd3;
    localparam logic [2:0] CMD_READ  = 3'd4;
    localparam logic [2:0] CMD_WRITE = 3'd5;

    localparam int ST_WIP = 0;
    localparam int ST_WEL = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN_I,
        S_WREN_W,
        S_WR_I,
        S_WR_W,
        S_RDSR_I,
        S_RDSR_W,
        S_GAP,
        S_RD_I,
        S_RD_W,
        S_RESP
    } seq_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin arbiter. Contention goes to the index that did not
// win last; last_grant only moves when a grant is actually issued.
module rr_arbiter_2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    logic last_grant_q;

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

    // Reset to 1 so requester A wins the first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b1;
        end else if (enable_i && (|req_i)) begin
            last_grant_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/eeprom_access_sequencer.sv
// Expands single-byte read/write requests from two requesters into AT25010
// command sequences (WREN/WRITE/RDSR polling, or READ) and returns one response each.
module eeprom_access_sequencer
    import eeprom_pkg::*;
#(
    parameter int POLL_GAP   = 16,
    parameter int MAX_POLLS  = 255,
    parameter int POLL_CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_write,
    input  logic [13:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_type,
    output logic [6:0]  cmd_addr,
    output logic [7:0]  cmd_wdata,
    input  logic [7:0]  cmd_rdata,
    input  logic        cmd_done,
    input  logic        cmd_error
);

    localparam logic [POLL_CNT_W-1:0] MAX_POLLS_C = POLL_CNT_W'(MAX_POLLS);
    localparam logic [POLL_CNT_W-1:0] GAP_LAST_C  = POLL_CNT_W'(POLL_GAP - 1);

    seq_state_t            state_q;
    logic                  owner_q;
    logic [6:0]            addr_q;
    logic [7:0]            wdata_q;
    logic [POLL_CNT_W-1:0] poll_cnt_q;
    logic [POLL_CNT_W-1:0] poll_cnt_d;
    logic [POLL_CNT_W-1:0] gap_cnt_q;
    logic                  cmd_valid_q;
    logic [2:0]            cmd_type_q;
    logic [6:0]            cmd_addr_q;
    logic [7:0]            cmd_wdata_q;
    logic [1:0]            rsp_valid_q;
    logic [7:0]            rsp_rdata_q;
    logic                  rsp_error_q;
    logic                  busy_q;

    logic [1:0] grant;
    logic       gidx;
    logic [6:0] g_addr;
    logic [7:0] g_wdata;
    logic [1:0] owner_mask;

    rr_arbiter_2 u_arb (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req_valid),
        .enable_i (state_q == S_IDLE),
        .grant_o  (grant)
    );

    assign gidx       = grant[1];
    assign g_addr     = gidx ? req_addr[13:7] : req_addr[6:0];
    assign g_wdata    = gidx ? req_wdata[15:8] : req_wdata[7:0];
    assign owner_mask = owner_q ? 2'b10 : 2'b01;
    assign poll_cnt_d = poll_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            poll_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= CMD_WREN;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (|grant) begin
                        owner_q     <= gidx;
                        addr_q      <= g_addr;
                        wdata_q     <= g_wdata;
                        busy_q      <= 1'b1;
                        cmd_valid_q <= 1'b1;
                        cmd_wdata_q <= '0;
                        if (req_write[gidx]) begin
                            state_q    <= S_WREN_I;
                            cmd_type_q <= CMD_WREN;
                            cmd_addr_q <= '0;
                        end else begin
                            state_q    <= S_RD_I;
                            cmd_type_q <= CMD_READ;
                            cmd_addr_q <= g_addr;
                        end
                    end
                end
                S_WREN_I, S_WR_I, S_RDSR_I, S_RD_I: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        case (state_q)
                            S_WREN_I: state_q <= S_WREN_W;
                            S_WR_I:   state_q <= S_WR_W;
                            S_RDSR_I: state_q <= S_RDSR_W;
                            default:  state_q <= S_RD_W;
                        endcase
                    end
                end
                S_WREN_W, S_WR_W, S_RDSR_W, S_RD_W: begin
                    // Error wins over a simultaneous done and aborts the sequence.
                    if (cmd_error) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= owner_mask;
                        rsp_rdata_q <= '0;
                        rsp_error_q <= 1'b1;
                    end else if (cmd_done) begin
                        case (state_q)
                            S_WREN_W: begin
                                state_q     <= S_WR_I;
                                cmd_valid_q <= 1'b1;
                                cmd_type_q  <= CMD_WRITE;
                                cmd_addr_q  <= addr_q;
                                cmd_wdata_q <= wdata_q;
                            end
                            S_WR_W: begin
                                state_q     <= S_RDSR_I;
                                poll_cnt_q  <= '0;
                                cmd_valid_q <= 1'b1;
                                cmd_type_q  <= CMD_RDSR;
                                cmd_addr_q  <= '0;
                                cmd_wdata_q <= '0;
                            end
                            S_RDSR_W: begin
                                poll_cnt_q <= poll_cnt_d;
                                if (!cmd_rdata[ST_WIP]) begin
                                    state_q     <= S_RESP;
                                    rsp_valid_q <= owner_mask;
                                    rsp_rdata_q <= '0;
                                    rsp_error_q <= 1'b0;
                                end else if (poll_cnt_d == MAX_POLLS_C) begin
                                    state_q     <= S_RESP;
                                    rsp_valid_q <= owner_mask;
                                    rsp_rdata_q <= '0;
                                    rsp_error_q <= 1'b1;
                                end else begin
                                    state_q   <= S_GAP;
                                    gap_cnt_q <= '0;
                                end
                            end
                            default: begin
                                state_q     <= S_RESP;
                                rsp_valid_q <= owner_mask;
                                rsp_rdata_q <= cmd_rdata;
                                rsp_error_q <= 1'b0;
                            end
                        endcase
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST_C) begin
                        state_q     <= S_RDSR_I;
                        cmd_valid_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    cmd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign busy      = busy_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_type  = cmd_type_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_wdata = cmd_wdata_q;

endmodule
